// File: rtl/vred_tree_acc.sv
// Pipelined vector reduction unit. Each beat of packed vs2 elements is reduced to one
// SEW-wide element through a registered halving tree. The per-beat results are then folded
// into a running accumulator that is seeded from vs1[0] on the start beat.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_start/in_end beat qualifiers; there is no backpressure
//   in_vec0                  vs2 beat (packed elements)
//   in_vec1                  seed; only [SEW-1:0] is used, and only on the start beat
//   in_opSel, in_sew         op (0 sum,1 minu,2 min,3 maxu,4 max,5 and,6 or,7 xor) and element width code
//   in_addr                  writeback address, taken from the end beat
//   out_vec/out_addr         result element (zero-extended) and the address of its end beat
//   out_valid                one-cycle result strobe, NSTAGE+2 edges after the end beat
module vred_tree_acc #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned OPSEL_WIDTH = 3,
    parameter int unsigned SEW_WIDTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_start,
    input  logic                   in_end,
    input  logic [DATA_WIDTH-1:0]  in_vec0,
    input  logic [DATA_WIDTH-1:0]  in_vec1,
    input  logic [OPSEL_WIDTH-1:0] in_opSel,
    input  logic [SEW_WIDTH-1:0]   in_sew,
    input  logic [ADDR_WIDTH-1:0]  in_addr,
    output logic [DATA_WIDTH-1:0]  out_vec,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic                   out_valid
);

    localparam int unsigned NSTAGE = $clog2(DATA_WIDTH / 8);
    // Operand width for the lane function; at least one full 64-bit element.
    localparam int unsigned PW     = (DATA_WIDTH < 64) ? 64 : DATA_WIDTH;

    localparam logic [2:0] OP_SUM  = 3'd0;
    localparam logic [2:0] OP_MINU = 3'd1;
    localparam logic [2:0] OP_MIN  = 3'd2;
    localparam logic [2:0] OP_MAXU = 3'd3;
    localparam logic [2:0] OP_MAX  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd6;

    // Element width in bits for a SEW code.
    function automatic int unsigned sew_bits(input logic [1:0] s);
        return 32'd8 << s;
    endfunction

    // Mask that keeps only the low SEW bits of a beat-wide word.
    function automatic logic [DATA_WIDTH-1:0] sew_mask(input logic [1:0] s);
        if (sew_bits(s) >= DATA_WIDTH) return '1;
        return (DATA_WIDTH'(1) << sew_bits(s)) - DATA_WIDTH'(1);
    endfunction

    // One element op. Only the low SEW bits of the result are meaningful.
    function automatic logic [63:0] elem_op(input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] op, input logic [1:0] sew);
        int unsigned        sh;
        logic [63:0]        a_u, b_u, res;
        logic signed [63:0] a_s, b_s;
        logic               lt_u, lt_s;
        sh   = 32'd64 - sew_bits(sew);
        a_u  = (a << sh) >> sh;
        b_u  = (b << sh) >> sh;
        a_s  = $signed(a << sh) >>> sh;
        b_s  = $signed(b << sh) >>> sh;
        lt_u = a_u < b_u;
        lt_s = a_s < b_s;
        case (op)
            OP_SUM:  res = a + b;
            OP_MINU: res = lt_u ? a : b;
            OP_MIN:  res = lt_s ? a : b;
            OP_MAXU: res = lt_u ? b : a;
            OP_MAX:  res = lt_s ? b : a;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            default: res = a ^ b;
        endcase
        return res;
    endfunction

    // Lane-wise op across a whole word, one SEW element per lane.
    function automatic logic [PW-1:0] vec_op(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                             input logic [2:0] op, input logic [1:0] sew);
        logic [PW-1:0] r;
        r = '0;
        case (sew)
            2'd0: for (int k = 0; k < int'(PW / 8); k++)
                      r[k*8 +: 8] = 8'(elem_op(64'(a[k*8 +: 8]), 64'(b[k*8 +: 8]), op, sew));
            2'd1: for (int k = 0; k < int'(PW / 16); k++)
                      r[k*16 +: 16] = 16'(elem_op(64'(a[k*16 +: 16]), 64'(b[k*16 +: 16]), op, sew));
            2'd2: for (int k = 0; k < int'(PW / 32); k++)
                      r[k*32 +: 32] = 32'(elem_op(64'(a[k*32 +: 32]), 64'(b[k*32 +: 32]), op, sew));
            default: for (int k = 0; k < int'(PW / 64); k++)
                      r[k*64 +: 64] = elem_op(a[k*64 +: 64], b[k*64 +: 64], op, sew);
        endcase
        return r;
    endfunction

    // Pipe index 0 is the input register; index i+1 is the output of tree stage i.
    logic                  r_vld  [0:NSTAGE];
    logic                  r_st   [0:NSTAGE];
    logic                  r_en   [0:NSTAGE];
    logic [2:0]            r_op   [0:NSTAGE];
    logic [1:0]            r_sew  [0:NSTAGE];
    logic [DATA_WIDTH-1:0] r_data [0:NSTAGE];
    logic [DATA_WIDTH-1:0] r_seed [0:NSTAGE];
    logic [ADDR_WIDTH-1:0] r_addr [0:NSTAGE];

    logic                  r_active;
    logic [2:0]            r_lop;
    logic [1:0]            r_lsew;
    logic [DATA_WIDTH-1:0] r_acc;
    logic                  r_a_done;
    logic [1:0]            r_a_sew;
    logic [ADDR_WIDTH-1:0] r_a_addr;

    logic [2:0]            w_op_in;
    logic [1:0]            w_sew_in;
    logic                  w_take_start;
    logic                  w_take;
    logic [DATA_WIDTH-1:0] w_nxt [0:NSTAGE-1];
    logic [DATA_WIDTH-1:0] w_acc_nxt;

    assign w_op_in  = 3'(in_opSel);
    assign w_sew_in = 2'(in_sew);

    // A start beat opens a reduction only if its element fits in a beat; other beats need an open one.
    assign w_take_start = in_valid && in_start && (sew_bits(w_sew_in) <= DATA_WIDTH);
    assign w_take       = w_take_start || (in_valid && !in_start && r_active);

    // Halving tree: fold the upper half of the live region onto the lower half while lanes still hold an element.
    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
        localparam int unsigned           LW    = DATA_WIDTH >> (gi + 1);
        localparam logic [DATA_WIDTH-1:0] LMASK = {{(DATA_WIDTH - LW){1'b0}}, {LW{1'b1}}};
        assign w_nxt[gi] = (LW >= sew_bits(r_sew[gi]))
            ? ((r_data[gi] & ~LMASK)
               | (DATA_WIDTH'(vec_op(PW'(r_data[gi] >> LW), PW'(r_data[gi]), r_op[gi], r_sew[gi])) & LMASK))
            : r_data[gi];
    end

    // Fold this beat's tree result into the seed (start beat) or into the running accumulator.
    assign w_acc_nxt = DATA_WIDTH'(vec_op(PW'(r_data[NSTAGE]),
                                          PW'(r_st[NSTAGE] ? r_seed[NSTAGE] : r_acc),
                                          r_op[NSTAGE], r_sew[NSTAGE]));

    // Control state: reduction tracking, pipe valids, accumulator and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_lop     <= '0;
            r_lsew    <= '0;
            for (int i = 0; i <= int'(NSTAGE); i++) r_vld[i] <= 1'b0;
            r_acc     <= '0;
            r_a_done  <= 1'b0;
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_addr  <= '0;
        end else begin
            if (w_take_start) begin
                r_active <= !in_end;
                r_lop    <= w_op_in;
                r_lsew   <= w_sew_in;
            end else if (w_take && in_end) begin
                r_active <= 1'b0;
            end
            r_vld[0] <= w_take;
            for (int i = 0; i < int'(NSTAGE); i++) r_vld[i+1] <= r_vld[i];
            if (r_vld[NSTAGE]) r_acc <= w_acc_nxt;
            r_a_done  <= r_vld[NSTAGE] && r_en[NSTAGE];
            out_valid <= r_a_done;
            if (r_a_done) begin
                out_vec  <= r_acc & sew_mask(r_a_sew);
                out_addr <= r_a_addr;
            end
        end
    end

    // Payload travelling alongside the valids; only meaningful where the matching valid is set.
    always_ff @(posedge clk) begin
        r_st[0]   <= in_start;
        r_en[0]   <= in_end;
        r_op[0]   <= in_start ? w_op_in  : r_lop;
        r_sew[0]  <= in_start ? w_sew_in : r_lsew;
        r_data[0] <= in_vec0;
        r_seed[0] <= in_vec1;
        r_addr[0] <= in_addr;
        for (int i = 0; i < int'(NSTAGE); i++) begin
            r_st[i+1]   <= r_st[i];
            r_en[i+1]   <= r_en[i];
            r_op[i+1]   <= r_op[i];
            r_sew[i+1]  <= r_sew[i];
            r_data[i+1] <= w_nxt[i];
            r_seed[i+1] <= r_seed[i];
            r_addr[i+1] <= r_addr[i];
        end
        r_a_sew  <= r_sew[NSTAGE];
        r_a_addr <= r_addr[NSTAGE];
    end

endmodule

// File: tb/tb_vred_tree_acc.sv
// Directed bench: a 64-bit instance (table of single-beat reductions plus multi-beat
// sequences) and a 16-bit instance for narrow-beat and oversized-SEW behaviour.
module tb_vred_tree_acc;

    logic clk;
    logic rst;

    // 64-bit instance
    logic        a_valid, a_start, a_end;
    logic [63:0] a_vec0, a_vec1;
    logic [2:0]  a_op;
    logic [1:0]  a_sew;
    logic [31:0] a_addr;
    logic [63:0] a_out_vec;
    logic [31:0] a_out_addr;
    logic        a_out_valid;

    // 16-bit instance
    logic        b_valid, b_start, b_end;
    logic [15:0] b_vec0, b_vec1;
    logic [2:0]  b_op;
    logic [1:0]  b_sew;
    logic [31:0] b_addr;
    logic [15:0] b_out_vec;
    logic [31:0] b_out_addr;
    logic        b_out_valid;

    int n_checks = 0;
    int n_errors = 0;

    vred_tree_acc #(.DATA_WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_start(a_start), .in_end(a_end),
        .in_vec0(a_vec0), .in_vec1(a_vec1), .in_opSel(a_op), .in_sew(a_sew), .in_addr(a_addr),
        .out_vec(a_out_vec), .out_addr(a_out_addr), .out_valid(a_out_valid)
    );

    vred_tree_acc #(.DATA_WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_start(b_start), .in_end(b_end),
        .in_vec0(b_vec0), .in_vec1(b_vec1), .in_opSel(b_op), .in_sew(b_sew), .in_addr(b_addr),
        .out_vec(b_out_vec), .out_addr(b_out_addr), .out_valid(b_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct packed {
        logic [63:0] v0;
        logic [63:0] seed;
        logic [2:0]  op;
        logic [1:0]  sew;
        logic [31:0] addr;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat_a(input logic s, input logic e, input logic [63:0] v0, input logic [63:0] v1,
                          input logic [2:0] op, input logic [1:0] sew, input logic [31:0] addr);
        a_valid = 1'b1; a_start = s; a_end = e; a_vec0 = v0; a_vec1 = v1;
        a_op = op; a_sew = sew; a_addr = addr;
        @(posedge clk);
        #1;
        a_valid = 1'b0; a_start = 1'b0; a_end = 1'b0;
    endtask

    task automatic beat_b(input logic s, input logic e, input logic [15:0] v0, input logic [15:0] v1,
                          input logic [2:0] op, input logic [1:0] sew, input logic [31:0] addr);
        b_valid = 1'b1; b_start = s; b_end = e; b_vec0 = v0; b_vec1 = v1;
        b_op = op; b_sew = sew; b_addr = addr;
        @(posedge clk);
        #1;
        b_valid = 1'b0; b_start = 1'b0; b_end = 1'b0;
    endtask

    // Edges until out_valid rises (0 if it never does within the budget).
    task automatic wait_a(output int lat);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (a_out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic wait_b(output int lat);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (b_out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int seen;

        //            v0                     seed                   op    sew   addr          exp
        tbl[0]  = '{64'h0807060504030201, 64'h10,                3'd0, 2'd0, 32'h100, 64'h34};
        tbl[1]  = '{64'h0807060504030201, 64'h10,                3'd0, 2'd1, 32'h104, 64'h1420};
        tbl[2]  = '{64'h0807060504030201, 64'h10,                3'd0, 2'd2, 32'h108, 64'h0C0A0816};
        tbl[3]  = '{64'hFFFFFFFFFFFFFFFF, 64'h2,                 3'd0, 2'd3, 32'h10C, 64'h1};
        tbl[4]  = '{64'hFFFFFFFFFFFFFFFF, 64'h08,                3'd0, 2'd0, 32'h110, 64'h0};
        tbl[5]  = '{64'h807F01FF10203040, 64'h05,                3'd1, 2'd0, 32'h114, 64'h01};
        tbl[6]  = '{64'h807F01FF10203040, 64'h05,                3'd2, 2'd0, 32'h118, 64'h80};
        tbl[7]  = '{64'h807F01FF10203040, 64'h05,                3'd3, 2'd0, 32'h11C, 64'hFF};
        tbl[8]  = '{64'h807F01FF10203040, 64'h05,                3'd4, 2'd0, 32'h120, 64'h7F};
        tbl[9]  = '{64'hFFF10FFFFF1FF1FF, 64'hFFFF,              3'd5, 2'd1, 32'h124, 64'h0111};
        tbl[10] = '{64'h00F000010A000000, 64'h10,                3'd6, 2'd2, 32'h128, 64'h0AF00011};
        tbl[11] = '{64'h123456789ABCDEF0, 64'h0F0F0F0F0F0F0F0F,  3'd7, 2'd3, 32'h12C, 64'h1D3B597795B3D1FF};
        tbl[12] = '{64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF,  3'd4, 2'd3, 32'h130, 64'h7FFFFFFFFFFFFFFF};
        tbl[13] = '{64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF,  3'd1, 2'd3, 32'h134, 64'h7FFFFFFFFFFFFFFF};
        tbl[14] = '{64'h0000000000000000, 64'hABCDEF12,          3'd7, 2'd0, 32'h138, 64'h12};

        rst = 1'b1;
        a_valid = 0; a_start = 0; a_end = 0; a_vec0 = '0; a_vec1 = '0; a_op = '0; a_sew = '0; a_addr = '0;
        b_valid = 0; b_start = 0; b_end = 0; b_vec0 = '0; b_vec1 = '0; b_op = '0; b_sew = '0; b_addr = '0;
        idle(3);
        rst = 1'b0;

        check("reset_out_valid", 64'(a_out_valid), 64'h0);
        check("reset_out_vec",   a_out_vec,        64'h0);
        check("reset_out_addr",  64'(a_out_addr),  64'h0);
        check("reset16_out_valid", 64'(b_out_valid), 64'h0);

        // Single-beat reductions: latency, value, address, one-cycle strobe.
        for (int i = 0; i < 15; i++) begin
            beat_a(1'b1, 1'b1, tbl[i].v0, tbl[i].seed, tbl[i].op, tbl[i].sew, tbl[i].addr);
            wait_a(lat);
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd5);
            check($sformatf("tbl%0d_vec", i), a_out_vec, tbl[i].exp);
            check($sformatf("tbl%0d_addr", i), 64'(a_out_addr), 64'(tbl[i].addr));
            idle(1);
            check($sformatf("tbl%0d_strobe_low", i), 64'(a_out_valid), 64'h0);
        end

        // Two-beat signed min; later beat carries a different op/sew that must be ignored.
        beat_a(1'b1, 1'b0, 64'hFFFFFFF0_00000005, 64'h3, 3'd2, 2'd2, 32'h10);
        beat_a(1'b0, 1'b1, 64'h7FFFFFFF_80000000, 64'h0, 3'd0, 2'd0, 32'h20);
        wait_a(lat);
        check("min2_latency", 64'(lat), 64'd5);
        check("min2_vec", a_out_vec, 64'h80000000);
        check("min2_addr", 64'(a_out_addr), 64'h20);

        beat_a(1'b1, 1'b0, 64'hFFFFFFF0_00000005, 64'h3, 3'd1, 2'd2, 32'h10);
        beat_a(1'b0, 1'b1, 64'h7FFFFFFF_80000000, 64'h0, 3'd7, 2'd3, 32'h20);
        wait_a(lat);
        check("minu2_vec", a_out_vec, 64'h3);

        // Same reduction with bubbles between beats.
        beat_a(1'b1, 1'b0, 64'hFFFFFFF0_00000005, 64'h3, 3'd2, 2'd2, 32'h40);
        idle(3);
        beat_a(1'b0, 1'b1, 64'h7FFFFFFF_80000000, 64'h0, 3'd2, 2'd2, 32'h80);
        wait_a(lat);
        check("bubble_latency", 64'(lat), 64'd5);
        check("bubble_vec", a_out_vec, 64'h80000000);
        check("bubble_addr", 64'(a_out_addr), 64'h80);

        // End at t, start&end at t+1: two adjacent pulses.
        beat_a(1'b1, 1'b0, 64'hF0, 64'h0F, 3'd7, 2'd3, 32'h200);
        beat_a(1'b0, 1'b1, 64'h100, 64'h0, 3'd0, 2'd0, 32'h204);
        beat_a(1'b1, 1'b1, 64'h0807060504030201, 64'h03, 3'd3, 2'd0, 32'h208);
        wait_a(lat);
        check("b2b_first_latency", 64'(lat), 64'd4);
        check("b2b_first_vec", a_out_vec, 64'h1FF);
        check("b2b_first_addr", 64'(a_out_addr), 64'h204);
        idle(1);
        check("b2b_second_valid", 64'(a_out_valid), 64'h1);
        check("b2b_second_vec", a_out_vec, 64'h08);
        check("b2b_second_addr", 64'(a_out_addr), 64'h208);
        idle(1);
        check("b2b_strobe_low", 64'(a_out_valid), 64'h0);

        // A new start discards the open reduction.
        beat_a(1'b1, 1'b0, 64'h1, 64'h1, 3'd0, 2'd0, 32'h300);
        beat_a(1'b1, 1'b1, 64'h2, 64'h3, 3'd0, 2'd0, 32'h304);
        wait_a(lat);
        check("restart_vec", a_out_vec, 64'h5);
        check("restart_addr", 64'(a_out_addr), 64'h304);

        // Reset mid-reduction with the end beat in flight, then orphan beats.
        beat_a(1'b1, 1'b0, 64'h11, 64'h1, 3'd0, 2'd0, 32'h400);
        beat_a(1'b0, 1'b1, 64'h22, 64'h0, 3'd0, 2'd0, 32'h404);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        seen = 0;
        beat_a(1'b0, 1'b1, 64'h33, 64'h0, 3'd0, 2'd0, 32'h408);
        beat_a(1'b0, 1'b0, 64'h44, 64'h0, 3'd0, 2'd0, 32'h40C);
        beat_a(1'b0, 1'b1, 64'h55, 64'h0, 3'd0, 2'd0, 32'h410);
        for (int c = 0; c < 15; c++) begin
            if (a_out_valid) seen = 1;
            idle(1);
        end
        check("rst_abort_no_valid", 64'(seen), 64'h0);
        check("rst_abort_vec", a_out_vec, 64'h0);
        check("rst_abort_addr", 64'(a_out_addr), 64'h0);

        // 16-bit instance: one tree stage, latency 3.
        beat_b(1'b1, 1'b1, 16'h0201, 16'h10, 3'd0, 2'd0, 32'h11);
        wait_b(lat);
        check("w16_sum8_latency", 64'(lat), 64'd3);
        check("w16_sum8_vec", 64'(b_out_vec), 64'h13);
        check("w16_sum8_addr", 64'(b_out_addr), 64'h11);

        beat_b(1'b1, 1'b1, 16'h1234, 16'h0001, 3'd0, 2'd1, 32'h12);
        wait_b(lat);
        check("w16_sum16_vec", 64'(b_out_vec), 64'h1235);

        beat_b(1'b1, 1'b1, 16'hFFFF, 16'h1234, 3'd7, 2'd1, 32'h13);
        wait_b(lat);
        check("w16_xor16_vec", 64'(b_out_vec), 64'hEDCB);

        beat_b(1'b1, 1'b1, 16'h807F, 16'h0000, 3'd2, 2'd0, 32'h14);
        wait_b(lat);
        check("w16_min8_vec", 64'(b_out_vec), 64'h80);

        beat_b(1'b1, 1'b1, 16'h807F, 16'h0000, 3'd4, 2'd0, 32'h15);
        wait_b(lat);
        check("w16_max8_vec", 64'(b_out_vec), 64'h7F);

        // Oversized SEW start beats are dropped and do not open a reduction.
        beat_b(1'b1, 1'b1, 16'h1111, 16'h1, 3'd0, 2'd3, 32'h20);
        wait_b(lat);
        check("w16_sew64_dropped", 64'(lat), 64'd0);

        beat_b(1'b1, 1'b1, 16'h1111, 16'h1, 3'd0, 2'd2, 32'h21);
        wait_b(lat);
        check("w16_sew32_dropped", 64'(lat), 64'd0);

        beat_b(1'b1, 1'b0, 16'h1111, 16'h1, 3'd0, 2'd3, 32'h22);
        beat_b(1'b0, 1'b1, 16'h2222, 16'h0, 3'd0, 2'd0, 32'h23);
        wait_b(lat);
        check("w16_not_opened", 64'(lat), 64'd0);
        check("w16_hold_vec", 64'(b_out_vec), 64'h7F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
